// File: rtl/cpu_stack_unit.sv
// cpu_stack_unit: operand stack with pop/push commit, registered bypassed reads, sp restore and sticky error flags
module cpu_stack_unit #(
    parameter int DATA_W = 35,
    parameter int SP_W   = 11,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              commit_valid,
    input  logic [SP_W-1:0]   commit_pop,
    input  logic              commit_push,
    input  logic [DATA_W-1:0] commit_data,
    input  logic              restore,
    input  logic [SP_W-1:0]   restore_sp,
    input  logic [SP_W-1:0]   rd_n,
    input  logic              err_clr,
    output logic [DATA_W-1:0] top_0,
    output logic              top_0_valid,
    output logic [DATA_W-1:0] top_n,
    output logic              top_n_valid,
    output logic [SP_W-1:0]   sp,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 2**SP_W;
    localparam logic [SP_W-1:0] ONE = SP_W'(1);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d, base, a0, an;
    logic [SP_W:0]     sum;
    logic              act, uf, of, we;
    logic [DATA_W-1:0] top_0_q, top_0_d, top_n_q, top_n_d;
    logic              top_0_valid_q, top_0_valid_d, top_n_valid_q, top_n_valid_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    always_comb begin
        act           = commit_valid && !restore;
        base          = sp_q - commit_pop;
        sum           = {1'b0, base} + {{SP_W{1'b0}}, commit_push};
        uf            = act && (commit_pop > sp_q);
        of            = act && !uf && sum[SP_W];
        we            = act && !uf && !of && commit_push;
        sp_d          = restore ? restore_sp : uf ? '0 : (act && !of) ? sum[SP_W-1:0] : sp_q;
        a0            = sp_d - ONE;
        an            = a0 - rd_n;
        top_0_valid_d = sp_d != '0;
        top_n_valid_d = rd_n < sp_d;
        top_0_d       = !top_0_valid_d ? '0 : (BYPASS && we && base == a0) ? commit_data : mem[a0];
        top_n_d       = !top_n_valid_d ? '0 : (BYPASS && we && base == an) ? commit_data : mem[an];
        overflow_d    = (overflow_q && !err_clr) || of;
        underflow_d   = (underflow_q && !err_clr) || uf;
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sp_q          <= '0;
            top_0_q       <= '0;
            top_n_q       <= '0;
            top_0_valid_q <= 1'b0;
            top_n_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            sp_q          <= sp_d;
            top_0_q       <= top_0_d;
            top_n_q       <= top_n_d;
            top_0_valid_q <= top_0_valid_d;
            top_n_valid_q <= top_n_valid_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end
    // Array is not reset; a write coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (we && rst_b) mem[base] <= commit_data;
    end
    assign top_0       = top_0_q;
    assign top_n       = top_n_q;
    assign top_0_valid = top_0_valid_q;
    assign top_n_valid = top_n_valid_q;
    assign sp          = sp_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
endmodule

// File: tb/tb_cpu_stack_unit.sv
// tb_cpu_stack_unit: directed plus random checks of two stack instances (bypass on/off) against an array model
module tb_cpu_stack_unit;
    localparam int DW = 35;
    localparam int SW = 4;
    localparam int CAP = 15;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_b, cv, push, rs, clr;
    logic [SW-1:0] pop, rsp, rdn;
    logic [DW-1:0] data;
    logic [DW-1:0] t0_a, tn_a, t0_b, tn_b;
    logic v0_a, vn_a, v0_b, vn_b, of_a, uf_a, of_b, uf_b;
    logic [SW-1:0] sp_a, sp_b;
    logic [DW-1:0] mm [16];
    int msp;
    bit mof, muf, ev0, evn;
    logic [DW-1:0] e0a, e0b, ena, enb;
    int n_cmp = 0;
    int n_bad = 0;

    cpu_stack_unit #(.DATA_W(DW), .SP_W(SW), .BYPASS(1'b1)) u_a (
        .clk(clk), .rst_b(rst_b), .commit_valid(cv), .commit_pop(pop), .commit_push(push),
        .commit_data(data), .restore(rs), .restore_sp(rsp), .rd_n(rdn), .err_clr(clr),
        .top_0(t0_a), .top_0_valid(v0_a), .top_n(tn_a), .top_n_valid(vn_a),
        .sp(sp_a), .overflow(of_a), .underflow(uf_a));
    cpu_stack_unit #(.DATA_W(DW), .SP_W(SW), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst_b(rst_b), .commit_valid(cv), .commit_pop(pop), .commit_push(push),
        .commit_data(data), .restore(rs), .restore_sp(rsp), .rd_n(rdn), .err_clr(clr),
        .top_0(t0_b), .top_0_valid(v0_b), .top_n(tn_b), .top_n_valid(vn_b),
        .sp(sp_b), .overflow(of_b), .underflow(uf_b));

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("sp_a", DW'(sp_a), DW'(msp));
        chk("sp_b", DW'(sp_b), DW'(msp));
        chk("ovf_a", DW'(of_a), DW'(mof));
        chk("unf_a", DW'(uf_a), DW'(muf));
        chk("ovf_b", DW'(of_b), DW'(mof));
        chk("unf_b", DW'(uf_b), DW'(muf));
        chk("v0_a", DW'(v0_a), DW'(ev0));
        chk("vn_a", DW'(vn_a), DW'(evn));
        chk("v0_b", DW'(v0_b), DW'(ev0));
        chk("vn_b", DW'(vn_b), DW'(evn));
        chk("top0_a", t0_a, e0a);
        chk("topn_a", tn_a, ena);
        chk("top0_b", t0_b, e0b);
        chk("topn_b", tn_b, enb);
    endtask

    // Drive one cycle of inputs, predict the post-edge state, then check both instances
    task automatic step(input bit c, input int p, input bit pu, input logic [DW-1:0] d,
                        input bit r, input int rp, input int rn, input bit cl);
        int spn = msp;
        int wa = 0;
        bit wr = 0, uf = 0, of = 0;
        cv = c; pop = SW'(p); push = pu; data = d; rs = r; rsp = SW'(rp); rdn = SW'(rn); clr = cl;
        if (r) spn = rp;
        else if (c) begin
            if (p > msp) begin uf = 1; spn = 0; end
            else if (msp - p + int'(pu) > CAP) of = 1;
            else begin spn = msp - p + int'(pu); wa = msp - p; wr = pu; end
        end
        ev0 = spn > 0;
        evn = rn < spn;
        e0b = ev0 ? mm[spn-1] : '0;
        e0a = (ev0 && wr && wa == spn - 1) ? d : e0b;
        enb = evn ? mm[spn-1-rn] : '0;
        ena = (evn && wr && wa == spn - 1 - rn) ? d : enb;
        if (wr) mm[wa] = d;
        msp = spn;
        mof = (mof && !cl) || of;
        muf = (muf && !cl) || uf;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic model_reset();
        msp = 0; mof = 0; muf = 0; ev0 = 0; evn = 0;
        e0a = '0; e0b = '0; ena = '0; enb = '0;
    endtask

    initial begin
        logic [DW-1:0] rnd;
        rst_b = 1'b0; cv = 0; pop = '0; push = 0; data = '0; rs = 0; rsp = '0; rdn = '0; clr = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_b = 1'b1;
        step(1, 0, 1, 'h11, 0, 0, 0, 0);
        step(1, 0, 1, 'h22, 0, 0, 0, 0);
        step(1, 0, 1, 'h33, 0, 0, 2, 0);
        step(1, 2, 1, 'h44, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 2, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < CAP; i++) step(1, 0, 1, DW'('h100 + i), 0, 0, i, 0);
        step(1, 0, 1, 'h55, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 'h77, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 5, 4, 0);
        step(1, 0, 1, 'h99, 1, 2, 1, 0);
        step(0, 0, 0, 0, 1, 6, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 1, 1, 'h66, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            rnd = DW'({$urandom, $urandom});
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2)),
                 $urandom_range(0, 2) != 0, rnd,
                 $urandom_range(0, 15) == 0, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
        end
        step(1, 0, 1, 'h1, 0, 0, 0, 0);
        step(1, 0, 1, 'h2, 0, 0, 0, 0);
        cv = 1; pop = '0; push = 1; data = 'h3; rs = 0; rdn = '0; clr = 0;
        #3;
        rst_b = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_b = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 'h5A, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_stack_unit.md
Name: cpu_stack_unit

Overview:
- Parametrised operand-stack store for the stack-machine pipeline.
- Replaces the fixed 35-bit / 11-bit-pointer stack embedded in decode.
- Writeback commits pop-count/push updates; decode reads top-of-stack and a second entry at arbitrary depth with 1-cycle registered latency and write bypass.
- Adds sp restore on pipeline kill, sticky overflow/underflow detection and read-valid flags.

Parameters:
- DATA_W, 35, entry width (32-bit value + 3-bit tag).
- SP_W, 11, pointer width; capacity 2**SP_W - 1 entries.
- BYPASS, 1, 1 = same-cycle commit data forwarded to read outputs; 0 = reads return pre-write array contents.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_b  in  1  asynchronous active-low reset.
- commit_valid  in  1  apply commit_pop/commit_push this cycle.
- commit_pop  in  SP_W  entries removed before the push.
- commit_push  in  1  push commit_data after popping.
- commit_data  in  DATA_W  value pushed.
- restore  in  1  load sp from restore_sp (kill recovery).
- restore_sp  in  SP_W  saved pointer.
- rd_n  in  SP_W  depth index for top_n (0 = top).
- top_0  out  DATA_W  registered entry at depth 0.
- top_0_valid  out  1  depth 0 exists.
- top_n  out  DATA_W  registered entry at depth rd_n.
- top_n_valid  out  1  depth rd_n exists.
- sp  out  SP_W  entry count / next free slot.
- overflow  out  1  sticky.
- underflow  out  1  sticky.
- err_clr  in  1  clears both sticky flags.

Behaviour:
- Reset (async, rst_b low): sp=0, top_0=top_n=0, both valids=0, overflow=underflow=0. Array contents are not reset.
- Storage: 2**SP_W x DATA_W array; entry k at address k; top at sp-1.
- Priority: restore > commit. With restore=1, sp_next=restore_sp; commit ignored (no write, no flags).
- Commit (commit_valid=1, restore=0): base=sp-commit_pop; write address=base; sp_next=base+commit_push.
- Underflow: commit_pop > sp. Set underflow; sp_next=0; no write.
- Overflow: base+commit_push > 2**SP_W-1. Set overflow; sp_next=sp unchanged; no write.
- Pop=0 with push=0 is a no-op with no flags.
- Flags: sticky until err_clr. err_clr with a new error in the same cycle leaves the flag set.
- Reads:
  - Addresses come from sp_next (post-commit view): a0=sp_next-1, an=sp_next-1-rd_n.
  - Outputs registered, valid the cycle after.
  - top_0_valid = (sp_next != 0); top_n_valid = (rd_n < sp_next).
  - Invalid read outputs 0.
- Bypass (BYPASS=1): if a write occurs this cycle at a0/an, the matching output takes commit_data. BYPASS=0 returns old array data.
- All pointer arithmetic is SP_W-bit unsigned; out-of-range cases are caught by the flag checks, never wrapped.
- Reset mid-operation: sp and flags return to 0 immediately. Any in-flight write is dropped. Stale array data is never visible because the valids are 0.

Test Plan:
- SP_W=4. Reset, push 0x11, 0x22, 0x33 on consecutive cycles -> sp=3; cycle after last push top_0=0x33, top_0_valid=1; rd_n=2 gives top_n=0x11.
- sp=3, commit pop=2 push=1 data=0x44 -> sp=2; next cycle top_0=0x44 (bypass), rd_n=1 gives top_n=0x11; rd_n=2 gives top_n_valid=0, top_n=0.
- sp=2, commit pop=3 -> underflow=1, sp=0, top_0_valid=0; err_clr -> underflow=0.
- Fill to sp=15, push 0x55 -> overflow=1, sp stays 15, entry 14 unchanged; pop=1 push=1 at sp=15 -> accepted, no new flag.
- sp=5, restore=1 restore_sp=2 with commit push same cycle -> sp=2, no write to address 5, next top_0 = old entry 1.
- BYPASS=0, sp=1, commit pop=1 push=1 data=0x66 -> top_0 shows old entry 0 for one cycle, then 0x66 once re-read.
- Assert rst_b low mid-push sequence -> all outputs 0 asynchronously; sp=0 after release.
